// File: rtl/lodn_pipe.sv
// Pipelined leading/trailing-one detector: radix-4 reduction tree, one register
// stage per tree level, valid/ready on both sides with a user sideband.
module lodn_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int USER_W = 4,
  localparam int IDX_W  = $clog2(WIDTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [WIDTH-1:0]  rx_data,
  input  logic              rx_mode,
  input  logic [USER_W-1:0] rx_user,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [IDX_W-1:0]  tx_data,
  output logic              tx_hotflag,
  output logic [USER_W-1:0] tx_user
);

  localparam int LEVELS = ($clog2(WIDTH) + 1) / 2;
  localparam int PADW   = 1 << (2 * LEVELS);

  function automatic logic [1:0] pick4(input logic [3:0] hot);
    logic [1:0] win;
    if (hot[3]) begin
      win = 2'd3;
    end else if (hot[2]) begin
      win = 2'd2;
    end else if (hot[1]) begin
      win = 2'd1;
    end else begin
      win = 2'd0;
    end
    return win;
  endfunction

  // Zero-extend to the padded width; mode 1 bit-reverses so the search is LSB-first.
  function automatic logic [PADW-1:0] entry_word(input logic [WIDTH-1:0] data, input logic mode);
    logic [PADW-1:0] pad;
    logic [PADW-1:0] res;
    pad = {PADW{1'b0}};
    pad[WIDTH-1:0] = data;
    for (int i = 0; i < PADW; i++) begin
      res[i] = mode ? pad[PADW-1-i] : pad[i];
    end
    return res;
  endfunction

  logic adv_s;
  assign adv_s    = !tx_valid || tx_ready;
  assign rx_ready = adv_s;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NODES = PADW >> (2 * (l + 1));
    localparam int IW    = 2 * (l + 1);

    logic                        in_valid_s;
    logic                        in_mode_s;
    logic [USER_W-1:0]           in_user_s;
    logic [NODES-1:0]            hot_s;
    logic [NODES-1:0][IW-1:0]    raw_s;
    logic [NODES-1:0][IW-1:0]    idx_s;
    logic                        valid_r;
    logic                        mode_r;
    logic [USER_W-1:0]           user_r;
    logic [NODES-1:0]            hot_r;
    logic [NODES-1:0][IW-1:0]    idx_r;

    if (l == 0) begin : g_leaf
      logic [PADW-1:0] leaf_s;
      assign leaf_s     = entry_word(rx_data, rx_mode);
      assign in_valid_s = rx_valid;
      assign in_mode_s  = rx_mode;
      assign in_user_s  = rx_user;
      for (genvar n = 0; n < NODES; n++) begin : g_node
        assign hot_s[n] = |leaf_s[4*n +: 4];
        assign raw_s[n] = pick4(leaf_s[4*n +: 4]);
      end
    end else begin : g_inner
      assign in_valid_s = g_lvl[l-1].valid_r;
      assign in_mode_s  = g_lvl[l-1].mode_r;
      assign in_user_s  = g_lvl[l-1].user_r;
      for (genvar n = 0; n < NODES; n++) begin : g_node
        logic [3:0]           ch_hot_s;
        logic [3:0][IW-3:0]   ch_idx_s;
        logic [1:0]           win_s;
        assign ch_hot_s = g_lvl[l-1].hot_r[4*n +: 4];
        assign ch_idx_s = g_lvl[l-1].idx_r[4*n +: 4];
        assign win_s    = pick4(ch_hot_s);
        assign hot_s[n] = |ch_hot_s;
        assign raw_s[n] = {win_s, ch_idx_s[win_s]};
      end
    end

    if (l == LEVELS - 1) begin : g_exit
      // Mirror the index back for LSB-first words; an all-zero word reports 0.
      always_comb begin
        idx_s = {(NODES * IW){1'b0}};
        for (int n = 0; n < NODES; n++) begin
          if (!hot_s[n]) begin
            idx_s[n] = {IW{1'b0}};
          end else if (in_mode_s) begin
            idx_s[n] = ~raw_s[n];
          end else begin
            idx_s[n] = raw_s[n];
          end
        end
      end
    end else begin : g_pass
      assign idx_s = raw_s;
    end

    // Stage register: shifts on advance, holds otherwise, empties on reset.
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        valid_r <= 1'b0;
        mode_r  <= 1'b0;
        user_r  <= {USER_W{1'b0}};
        hot_r   <= {NODES{1'b0}};
        idx_r   <= {(NODES * IW){1'b0}};
      end else if (adv_s) begin
        valid_r <= in_valid_s;
        mode_r  <= in_mode_s;
        user_r  <= in_user_s;
        hot_r   <= hot_s;
        idx_r   <= idx_s;
      end
    end
  end

  assign tx_valid   = g_lvl[LEVELS-1].valid_r;
  assign tx_hotflag = g_lvl[LEVELS-1].hot_r[0];
  assign tx_user    = g_lvl[LEVELS-1].user_r;
  assign tx_data    = g_lvl[LEVELS-1].idx_r[0][IDX_W-1:0];

  // The winner always lies below WIDTH, so the padded index MSBs and the last mode copy go nowhere.
  logic unused_s;
  assign unused_s = ^{g_lvl[LEVELS-1].mode_r, g_lvl[LEVELS-1].idx_r};

endmodule

// File: tb/tb_lodn_pipe.sv
// Bench for lodn_pipe (WIDTH=32, USER_W=4): directed cases plus a randomized
// stream scored against a bit-scan reference model.
module tb_lodn_pipe;

  localparam int WIDTH  = 32;
  localparam int USER_W = 4;
  localparam int IDX_W  = 5;
  localparam int LEVELS = 3;

  logic              aclk     = 1'b0;
  logic              areset   = 1'b0;
  logic              rx_valid = 1'b0;
  logic              rx_mode  = 1'b0;
  logic [WIDTH-1:0]  rx_data  = 32'h0;
  logic [USER_W-1:0] rx_user  = 4'h0;
  logic              tx_ready = 1'b1;
  logic              rx_ready;
  logic              tx_valid;
  logic              tx_hotflag;
  logic [IDX_W-1:0]  tx_data;
  logic [USER_W-1:0] tx_user;

  lodn_pipe #(.WIDTH(WIDTH), .USER_W(USER_W)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_mode    (rx_mode),
    .rx_user    (rx_user),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_hotflag (tx_hotflag),
    .tx_user    (tx_user)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic              hot;
    logic [IDX_W-1:0]  idx;
    logic [USER_W-1:0] user;
    int                acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  bit   chk_lat  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Highest set bit (mode 0) or lowest set bit (mode 1) by a direct scan.
  function automatic exp_t ref_model(input logic [WIDTH-1:0] d, input logic m,
                                     input logic [USER_W-1:0] u, input int c);
    exp_t r;
    r.hot  = (d != 32'h0);
    r.idx  = 5'd0;
    r.user = u;
    r.acc  = c;
    if (!m) begin
      for (int i = 0; i < WIDTH; i++) if (d[i]) r.idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) if (d[i]) r.idx = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1 << $urandom_range(0, 31);
      2:       return $urandom & $urandom & $urandom;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard and hold-stability monitor, sampling mid-cycle.
  initial begin : monitor
    logic              prev_hold;
    logic [IDX_W-1:0]  p_data;
    logic              p_hot;
    logic [USER_W-1:0] p_user;
    exp_t              e;
    prev_hold = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", tx_valid, 1'b1);
          check("hold_data", tx_data, p_data);
          check("hold_hot", tx_hotflag, p_hot);
          check("hold_user", tx_user, p_user);
        end
        if (rx_valid && rx_ready) sb_q.push_back(ref_model(rx_data, rx_mode, rx_user, cyc));
        if (tx_valid && tx_ready) begin
          n_out++;
          if (sb_q.size() == 0) begin
            check("unexpected_out", tx_valid, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check("out_data", tx_data, e.idx);
            check("out_hot", tx_hotflag, e.hot);
            check("out_user", tx_user, e.user);
            if (chk_lat) check("latency", cyc - e.acc, LEVELS);
          end
        end
        prev_hold = tx_valid && !tx_ready;
        p_data    = tx_data;
        p_hot     = tx_hotflag;
        p_user    = tx_user;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic m, input logic [USER_W-1:0] u);
    int waited;
    waited   = 0;
    rx_valid = 1'b1;
    rx_data  = d;
    rx_mode  = m;
    rx_user  = u;
    @(negedge aclk);
    while (!rx_ready && waited < 200) begin
      waited++;
      @(negedge aclk);
    end
    if (!rx_ready) check("send_timeout", rx_ready, 1'b1);
    step();
  endtask

  task automatic idle();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!tx_valid && n < 50);
    if (!tx_valid) check("tx_timeout", tx_valid, 1'b1);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && sb_q.size() != 0; i++) @(negedge aclk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: observed no finish expected finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int n0;
    bit done;

    #1 areset = 1'b1;
    @(negedge aclk);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 5'd0);
    check("rst_tx_hot", tx_hotflag, 1'b0);
    check("rst_tx_user", tx_user, 4'h0);
    step();
    areset = 1'b0;

    // Single MSB word, fixed latency.
    chk_lat = 1'b1;
    check("t1_rx_ready", rx_ready, 1'b1);
    send(32'h8000_0000, 1'b0, 4'hA);
    idle();
    wait_tx(n);
    check("t1_latency", n, LEVELS);
    check("t1_data", tx_data, 5'd31);
    check("t1_hot", tx_hotflag, 1'b1);
    check("t1_user", tx_user, 4'hA);

    // Same word in both directions, back to back.
    step();
    send(32'h0001_0100, 1'b0, 4'h3);
    send(32'h0001_0100, 1'b1, 4'h5);
    idle();
    wait_tx(n);
    check("t2_first", tx_data, 5'd16);
    @(negedge aclk);
    check("t2_second_valid", tx_valid, 1'b1);
    check("t2_second", tx_data, 5'd8);

    // All-zero word in both modes.
    step();
    send(32'h0, 1'b0, 4'h1);
    send(32'h0, 1'b1, 4'h2);
    idle();
    wait_tx(n);
    check("t3_hot_m0", tx_hotflag, 1'b0);
    check("t3_data_m0", tx_data, 5'd0);
    @(negedge aclk);
    check("t3_valid_m1", tx_valid, 1'b1);
    check("t3_hot_m1", tx_hotflag, 1'b0);
    check("t3_data_m1", tx_data, 5'd0);

    // Walking one with a downstream stall midway.
    step();
    chk_lat = 1'b0;
    n0 = n_out;
    for (int k = 0; k < WIDTH; k++) begin
      send(32'h1 << k, 1'b0, 4'(k));
      if (k == 15) begin
        idle();
        tx_ready = 1'b0;
        repeat (5) begin
          @(negedge aclk);
          check("t4_rx_ready_hold", rx_ready, 1'b0);
        end
        step();
        tx_ready = 1'b1;
      end
    end
    idle();
    drain(20);
    check("t4_count", n_out - n0, WIDTH);

    // Reset with words in flight.
    step();
    chk_lat = 1'b1;
    send(rand_word(), 1'b0, 4'h1);
    send(rand_word(), 1'b1, 4'h2);
    send(rand_word(), 1'b0, 4'h3);
    idle();
    areset = 1'b1;
    sb_q.delete();
    #1;
    check("t5_tx_valid", tx_valid, 1'b0);
    check("t5_tx_data", tx_data, 5'd0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    repeat (6) begin
      @(negedge aclk);
      check("t5_no_stale", tx_valid, 1'b0);
    end
    step();
    send(32'h0000_0040, 1'b1, 4'h7);
    idle();
    wait_tx(n);
    check("t5_latency", n, LEVELS);
    check("t5_data", tx_data, 5'd6);
    check("t5_user", tx_user, 4'h7);

    // Randomized stream with random backpressure.
    step();
    chk_lat = 1'b0;
    n0 = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            step();
          end
          send(rand_word(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          tx_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        tx_ready = 1'b1;
      end
    join
    drain(200);
    check("t6_count", n_out - n0, 10000);
    check("t6_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
